debounce_bank: RTL and testbench
================================

# debounce_bank

Parametrised multi-channel debouncer for push-buttons and switches. Each channel synchronises an asynchronous input, accepts a new level only after it has been stable for a programmable number of cycles, and provides:
- a debounced level;
- one-cycle rise and fall pulses;
- a toggle output;
- optionally, a long-press pulse.

It sits between board pins and control logic such as mode selects, counters and FSM triggers, and replaces single-channel edge detectors in new designs.

## Interface
- N_CH, 4, number of independent channels (≥1)
- STABLE_CYC, 50000, consecutive stable cycles required to accept a new level (≥1)
- CNT_W, 16, stability counter width; 2^CNT_W ≥ STABLE_CYC
- HOLD_CYC, 1000000, cycles of debounced-high before long_press fires (≥1)
- HOLD_W, 24, hold counter width; 2^HOLD_W > HOLD_CYC
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- din  in  N_CH  raw asynchronous inputs
- level  out  N_CH  debounced level
- rise  out  N_CH  one-cycle pulse on accepted 0→1
- fall  out  N_CH  one-cycle pulse on accepted 1→0
- toggle  out  N_CH  flips on each rise
- long_press  out  N_CH  one-cycle pulse after HOLD_CYC cycles high (see Configuration)

## Operation
- Channels are fully independent. Channel i uses only din[i].
- Each channel has a 2-FF synchroniser: s1 ← din, s2 ← s1.
- Stability counter cnt, evaluated on every edge:
  - s2 == level: cnt ← 0.
  - s2 ≠ level and cnt == STABLE_CYC−1: level ← s2, cnt ← 0. Also assert rise (if s2 = 1) or fall (if s2 = 0).
  - Otherwise: cnt ← cnt+1.
- Any single-cycle return of s2 to the current level clears cnt, so glitches shorter than STABLE_CYC cycles never change level.
- cnt never exceeds STABLE_CYC−1 and never wraps.
- rise, fall and long_press are registered. Each is high for exactly one cycle and never on consecutive cycles.
- rise and fall are mutually exclusive per channel.
- toggle ← ~toggle on the same edge at which rise asserts.
- Long press (macro enabled):
  - hold counter hcnt clears while level = 0.
  - hcnt increments while level = 1, saturating at HOLD_CYC.
  - long_press pulses on the edge hcnt reaches HOLD_CYC.
  - At most one long_press pulse per press. A fall re-arms it.
- Reset:
  - s1, s2, cnt, hcnt, level, rise, fall, toggle and long_press are all 0.
  - Reset asserted mid-debounce discards the in-progress count.
  - If din is held high through reset release, a normal rise (and toggle flip) follows after the standard latency. This is intended.

## Timing
- Let edge k be the first edge at which s1 samples a new din value that then stays stable.
  - s2 holds the new value after edge k+1.
  - level changes, and rise/fall asserts, at edge k+STABLE_CYC+1.
- With STABLE_CYC = 1, level follows din with 2 edges of latency (pure synchroniser plus register).
- long_press asserts HOLD_CYC edges after the edge at which level rose.
- Throughput: a channel can accept a new level at most once every STABLE_CYC cycles.

## Configuration
- DEBOUNCE_LONGPRESS_EN:
  - Defined: hcnt and long_press logic are built per channel as described in Operation.
  - Undefined: no hold counter is instantiated, and long_press is tied to all-zero. The port list is unchanged, so instantiations need no edits.

## Structure
- Shared package debounce_pkg holds:
  - default constants (DEF_STABLE_CYC, DEF_HOLD_CYC);
  - a width helper function for deriving CNT_W and HOLD_W.
- Sub-module debounce_chan implements one channel (synchroniser, stability counter, edge/toggle/long-press regs).
- The top level is a generate loop of N_CH debounce_chan instances. It contains no logic of its own.

## Test plan
All scenarios use N_CH = 2, STABLE_CYC = 4, HOLD_CYC = 10, macro defined unless stated.
- din[0] 0→1 and held after reset → level[0] rises and rise[0] pulses once at edge k+5; toggle[0] = 1; channel 1 stays all-zero.
- din[0] bounces 1,0,1,1,0 (one cycle each), then held 1 → no level change during the bounces; one rise 5 edges after the final stable 1 is sampled.
- Press and release twice, each phase ≥6 cycles → two rise and two fall pulses; toggle ends at 0; rise and fall are never simultaneous.
- Hold din[1] high for 20 cycles past acceptance → exactly one long_press[1] pulse 10 edges after rise[1]. Rebuild without the macro → long_press stays 0.
- Assert rst for 1 cycle mid-count with din[0] = 1 → all outputs 0 the cycle after reset; rise[0] fires 5 edges after reset release.
- Drive both channels with independent patterns simultaneously → per-channel results match the single-channel runs, with no cross-talk.

Source files
------------

// File: rtl/debounce_pkg.sv
// Shared constants and width helper for the debounce_bank slice.
package debounce_pkg;

    localparam int unsigned DEF_STABLE_CYC = 50000;
    localparam int unsigned DEF_HOLD_CYC   = 1000000;
    localparam int unsigned DEF_CNT_W      = 16;
    localparam int unsigned DEF_HOLD_W     = 24;

    // Number of bits needed to represent the value v (at least 1).
    function automatic int unsigned bits_for(input int unsigned v);
        int unsigned w;
        w = 1;
        while ((v >> w) != 0) w++;
        return w;
    endfunction

endpackage

// File: rtl/debounce_chan.sv
// One debounce channel: 2-FF synchroniser, stability counter, edge/toggle regs.
// Long-press hold counter is built only when DEBOUNCE_LONGPRESS_EN is defined.
module debounce_chan
    import debounce_pkg::*;
#(
    parameter int unsigned STABLE_CYC = DEF_STABLE_CYC,
    parameter int unsigned CNT_W      = DEF_CNT_W,
    parameter int unsigned HOLD_CYC   = DEF_HOLD_CYC,
    parameter int unsigned HOLD_W     = DEF_HOLD_W
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic level,
    output logic rise,
    output logic fall,
    output logic toggle,
    output logic long_press
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYC - 1);

    logic             s1_p0;
    logic             s2_p1;
    logic [CNT_W-1:0] cnt;
    logic             accept;

    // Stage p0/p1: two-flop synchroniser for the asynchronous pin
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_p0 <= 1'b0;
            s2_p1 <= 1'b0;
        end else begin
            s1_p0 <= din;
            s2_p1 <= s1_p0;
        end
    end

    assign accept = (s2_p1 != level) && (cnt == CNT_MAX);

    // Stability counter and registered level / edge / toggle outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt    <= '0;
            level  <= 1'b0;
            rise   <= 1'b0;
            fall   <= 1'b0;
            toggle <= 1'b0;
        end else begin
            rise <= accept && s2_p1;
            fall <= accept && !s2_p1;
            if (s2_p1 == level) begin
                cnt <= '0;
            end else if (accept) begin
                cnt   <= '0;
                level <= s2_p1;
                if (s2_p1) toggle <= ~toggle;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

`ifdef DEBOUNCE_LONGPRESS_EN
    localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(HOLD_CYC);
    localparam logic [HOLD_W-1:0] HOLD_PRE = HOLD_W'(HOLD_CYC - 1);

    logic [HOLD_W-1:0] hcnt;

    function automatic logic [HOLD_W-1:0] sat_inc(input logic [HOLD_W-1:0] v);
        return (v >= HOLD_MAX) ? HOLD_MAX : v + HOLD_W'(1);
    endfunction

    // Hold counter saturates, so the pulse fires only once per press
    always_ff @(posedge clk) begin
        if (rst) begin
            hcnt       <= '0;
            long_press <= 1'b0;
        end else if (!level) begin
            hcnt       <= '0;
            long_press <= 1'b0;
        end else begin
            hcnt       <= sat_inc(hcnt);
            long_press <= (hcnt == HOLD_PRE);
        end
    end
`else
    // Both parameters are >= 1, so this is constant zero; referencing them keeps
    // the parameter list meaningful in the build without the hold counter.
    assign long_press = (HOLD_CYC == 0) && (HOLD_W == 0);
`endif

endmodule

// File: rtl/debounce_bank.sv
// N_CH independent debounce channels; long-press logic depends on
// DEBOUNCE_LONGPRESS_EN (long_press is tied low when it is undefined).
module debounce_bank
    import debounce_pkg::*;
#(
    parameter int unsigned N_CH       = 4,
    parameter int unsigned STABLE_CYC = DEF_STABLE_CYC,
    parameter int unsigned CNT_W      = DEF_CNT_W,
    parameter int unsigned HOLD_CYC   = DEF_HOLD_CYC,
    parameter int unsigned HOLD_W     = DEF_HOLD_W
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N_CH-1:0] din,
    output logic [N_CH-1:0] level,
    output logic [N_CH-1:0] rise,
    output logic [N_CH-1:0] fall,
    output logic [N_CH-1:0] toggle,
    output logic [N_CH-1:0] long_press
);

    for (genvar i = 0; i < N_CH; i++) begin : g_chan
        debounce_chan #(
            .STABLE_CYC (STABLE_CYC),
            .CNT_W      (CNT_W),
            .HOLD_CYC   (HOLD_CYC),
            .HOLD_W     (HOLD_W)
        ) u_chan (
            .clk        (clk),
            .rst        (rst),
            .din        (din[i]),
            .level      (level[i]),
            .rise       (rise[i]),
            .fall       (fall[i]),
            .toggle     (toggle[i]),
            .long_press (long_press[i])
        );
    end

endmodule

// File: tb/tb_debounce_bank.sv
// Self-checking bench for debounce_bank: vector table, directed corner cases,
// and randomized traffic against a behavioural reference model.
module tb_debounce_bank;
    import debounce_pkg::*;

    localparam int unsigned N_CH       = 2;
    localparam int unsigned STABLE_CYC = 4;
    localparam int unsigned HOLD_CYC   = 10;
    localparam int unsigned CNT_W      = bits_for(STABLE_CYC);
    localparam int unsigned HOLD_W     = bits_for(HOLD_CYC);
`ifdef DEBOUNCE_LONGPRESS_EN
    localparam bit LP_EN = 1'b1;
`else
    localparam bit LP_EN = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            rst;
    logic [N_CH-1:0] din;
    logic [N_CH-1:0] level, rise, fall, toggle, long_press;

    debounce_bank #(
        .N_CH       (N_CH),
        .STABLE_CYC (STABLE_CYC),
        .CNT_W      (CNT_W),
        .HOLD_CYC   (HOLD_CYC),
        .HOLD_W     (HOLD_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .din        (din),
        .level      (level),
        .rise       (rise),
        .fall       (fall),
        .toggle     (toggle),
        .long_press (long_press)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: the synchronised value seen at an edge is the pin value
    // sampled two edges earlier; a level is accepted once it has disagreed with
    // the current level on STABLE_CYC consecutive edges.
    logic            m_q [N_CH][$];
    int              m_run [N_CH];
    int              m_rise_t [N_CH];
    int              m_t = 0;
    logic [N_CH-1:0] m_level = '0, m_rise = '0, m_fall = '0, m_tog = '0, m_lp = '0;

    task automatic model_edge(input logic r, input logic [N_CH-1:0] d);
        m_t++;
        for (int c = 0; c < N_CH; c++) begin
            logic sync;
            logic pre;
            if (r) begin
                m_q[c].delete();
                m_run[c]    = 0;
                m_rise_t[c] = -1;
                m_level[c]  = 1'b0;
                m_rise[c]   = 1'b0;
                m_fall[c]   = 1'b0;
                m_tog[c]    = 1'b0;
                m_lp[c]     = 1'b0;
            end else begin
                m_q[c].push_back(d[c]);
                if (m_q[c].size() > 3) void'(m_q[c].pop_front());
                sync = (m_q[c].size() == 3) ? m_q[c][0] : 1'b0;
                pre  = m_level[c];
                m_rise[c] = 1'b0;
                m_fall[c] = 1'b0;
                m_lp[c]   = LP_EN && pre && (m_rise_t[c] >= 0) &&
                            ((m_t - m_rise_t[c]) == int'(HOLD_CYC));
                m_run[c]  = (sync != pre) ? m_run[c] + 1 : 0;
                if (m_run[c] == int'(STABLE_CYC)) begin
                    m_run[c]   = 0;
                    m_level[c] = sync;
                    if (sync) begin
                        m_rise[c]   = 1'b1;
                        m_tog[c]    = ~m_tog[c];
                        m_rise_t[c] = m_t;
                    end else begin
                        m_fall[c] = 1'b1;
                    end
                end
            end
        end
    endtask

    task automatic check(input string name, input logic [N_CH-1:0] act, input logic [N_CH-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b, expected %b (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // One clock edge: drive at negedge, advance the model at posedge, compare at negedge.
    task automatic tick(input logic r, input logic [N_CH-1:0] d);
        rst = r;
        din = d;
        @(posedge clk);
        model_edge(r, d);
        @(negedge clk);
        check("model_level", level, m_level);
        check("model_rise", rise, m_rise);
        check("model_fall", fall, m_fall);
        check("model_toggle", toggle, m_tog);
        check("model_long_press", long_press, m_lp);
    endtask

    typedef struct {
        logic            r;
        logic [N_CH-1:0] d;
        logic [N_CH-1:0] lvl;
        logic [N_CH-1:0] rs;
        logic [N_CH-1:0] fl;
        logic [N_CH-1:0] tg;
    } vec_t;

    vec_t tbl [16];
    logic bseq [5];

    initial begin
        int rise_at, lp_at, n_rise, n_fall, n_both, early, xtalk;
        int   left [N_CH];
        logic cur  [N_CH];

        rst = 1'b1;
        din = '0;
        @(negedge clk);

        // Press on channel 0 from reset, then release; channel 1 stays idle
        tbl[0] = '{1'b1, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00};
        for (int i = 1; i <= 5; i++) tbl[i] = '{1'b0, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00};
        tbl[6] = '{1'b0, 2'b01, 2'b01, 2'b01, 2'b00, 2'b01};
        tbl[7] = '{1'b0, 2'b01, 2'b01, 2'b00, 2'b00, 2'b01};
        tbl[8] = '{1'b0, 2'b01, 2'b01, 2'b00, 2'b00, 2'b01};
        for (int i = 9; i <= 13; i++) tbl[i] = '{1'b0, 2'b00, 2'b01, 2'b00, 2'b00, 2'b01};
        tbl[14] = '{1'b0, 2'b00, 2'b00, 2'b00, 2'b01, 2'b01};
        tbl[15] = '{1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b01};
        for (int i = 0; i < 16; i++) begin
            tick(tbl[i].r, tbl[i].d);
            check($sformatf("tbl%0d_level", i), level, tbl[i].lvl);
            check($sformatf("tbl%0d_rise", i), rise, tbl[i].rs);
            check($sformatf("tbl%0d_fall", i), fall, tbl[i].fl);
            check($sformatf("tbl%0d_toggle", i), toggle, tbl[i].tg);
        end

        // Bounce 1,0,1,1,0 then hold high: single rise 5 edges after final stable 1
        bseq = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
        tick(1'b1, 2'b00);
        rise_at = -1; n_rise = 0; early = 0;
        for (int j = 0; j < 16; j++) begin
            tick(1'b0, {1'b0, (j < 5) ? bseq[j] : 1'b1});
            if (rise[0]) begin n_rise++; rise_at = j; end
            if (j < 10 && level[0]) early++;
        end
        check_int("bounce_rise_edge", rise_at, 10);
        check_int("bounce_rise_count", n_rise, 1);
        check_int("bounce_early_level", early, 0);

        // Press and release twice
        tick(1'b1, 2'b00);
        n_rise = 0; n_fall = 0; n_both = 0; xtalk = 0;
        for (int p = 0; p < 5; p++) begin
            for (int j = 0; j < 8; j++) begin
                tick(1'b0, {1'b0, (p < 4) && (p % 2 == 0)});
                if (rise[0]) n_rise++;
                if (fall[0]) n_fall++;
                if (rise[0] && fall[0]) n_both++;
                if (level[1] || rise[1] || toggle[1]) xtalk++;
            end
        end
        check_int("pr_rise_count", n_rise, 2);
        check_int("pr_fall_count", n_fall, 2);
        check_int("pr_rise_fall_overlap", n_both, 0);
        check_int("pr_crosstalk", xtalk, 0);
        check("pr_toggle_end", toggle, 2'b00);

        // Long hold on channel 1
        tick(1'b1, 2'b00);
        rise_at = -1; lp_at = -1; n_rise = 0;
        for (int j = 0; j < 26; j++) begin
            tick(1'b0, 2'b10);
            if (rise[1]) rise_at = j;
            if (long_press[1]) begin n_rise++; lp_at = j; end
        end
        check_int("lp_rise_edge", rise_at, 5);
        check_int("lp_pulse_count", n_rise, LP_EN ? 1 : 0);
        check_int("lp_pulse_edge", lp_at, LP_EN ? 15 : -1);
        for (int j = 0; j < 8; j++) tick(1'b0, 2'b00);

        // Reset mid-count with din held high
        tick(1'b1, 2'b00);
        for (int j = 0; j < 3; j++) tick(1'b0, 2'b01);
        tick(1'b1, 2'b01);
        check("rst_level", level, 2'b00);
        check("rst_rise", rise, 2'b00);
        check("rst_fall", fall, 2'b00);
        check("rst_toggle", toggle, 2'b00);
        check("rst_long_press", long_press, 2'b00);
        rise_at = -1;
        for (int j = 0; j < 9; j++) begin
            tick(1'b0, 2'b01);
            if (rise[0]) rise_at = j;
        end
        check_int("rst_release_rise_edge", rise_at, 5);
        check("rst_release_toggle", toggle, 2'b01);

        // Randomized independent traffic on both channels with occasional reset
        for (int c = 0; c < N_CH; c++) begin
            left[c] = 0;
            cur[c]  = 1'b0;
        end
        for (int n = 0; n < 1500; n++) begin
            logic [N_CH-1:0] d;
            for (int c = 0; c < N_CH; c++) begin
                if (left[c] == 0) begin
                    cur[c]  = ~cur[c];
                    left[c] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(10, 30))
                                                          : int'($urandom_range(1, 6));
                end
                left[c]--;
                d[c] = cur[c];
            end
            tick($urandom_range(0, 299) == 0, d);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
